// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation controller and its
// Montgomery multiplier: FSM encodings and multiplier slicing.
package mod_exp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TO_MONT   = 3'd1,
        ST_INIT      = 3'd2,
        ST_SQUARE    = 3'd3,
        ST_MULT      = 3'd4,
        ST_NEXT      = 3'd5,
        ST_FROM_MONT = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    typedef enum logic {
        SUB_LAUNCH = 1'b0,
        SUB_WAIT   = 1'b1
    } sub_e;

    // Multiplier bits consumed per clock when the width divides evenly.
    localparam int MP_SLICE = 16;

    function automatic int mp_slice_for(input int width);
        return (width % MP_SLICE == 0) ? MP_SLICE : 1;
    endfunction

endpackage

// File: rtl/mod_exp_mon_prod.sv
// Montgomery product P = A*B*2^-bitLen mod M, scanning A from the LSB,
// SLICE bits per clock, then one conditional final subtraction.
module mon_prod #(
    parameter int bitLen = 64,
    parameter int SLICE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [bitLen-1:0] A,
    input  logic [bitLen-1:0] B,
    input  logic [bitLen-1:0] M,
    output logic [bitLen-1:0] P,
    output logic              stop
);
    localparam int W     = bitLen + 2;
    localparam int STEPS = bitLen / SLICE;
    localparam int SCW   = $clog2(STEPS + 1);

    logic [bitLen-1:0] a_q, b_q, m_q, p_q, sub;
    logic [W-1:0]      acc_q, acc_d;
    logic [W:0]        t;
    logic [SCW-1:0]    step_q;
    logic              run_q, fin_q, stop_q;

    // Accumulator stays below M + B < 2M, so W bits hold it and W+1 hold each sum.
    always_comb begin
        acc_d = acc_q;
        t     = '0;
        for (int i = 0; i < SLICE; i++) begin
            t     = {1'b0, acc_d} + ({(W+1){a_q[i]}} & (W+1)'(b_q));
            t     = t + ({(W+1){t[0]}} & (W+1)'(m_q));
            acc_d = t[W:1];
        end
        sub = acc_q[bitLen-1:0] - m_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            p_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            fin_q  <= 1'b0;
            stop_q <= 1'b0;
        end else if (start) begin
            a_q    <= A;
            b_q    <= B;
            m_q    <= M;
            acc_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b1;
            fin_q  <= 1'b0;
            stop_q <= 1'b0;
        end else if (run_q) begin
            acc_q  <= acc_d;
            a_q    <= a_q >> SLICE;
            step_q <= step_q + SCW'(1);
            if (step_q == SCW'(STEPS - 1)) begin
                run_q <= 1'b0;
                fin_q <= 1'b1;
            end
        end else if (fin_q) begin
            p_q    <= (acc_q >= W'(m_q)) ? sub : acc_q[bitLen-1:0];
            fin_q  <= 1'b0;
            stop_q <= 1'b1;
        end
    end

    assign P    = p_q;
    assign stop = stop_q;

endmodule

// File: rtl/mod_exp.sv
// Y = X^E mod M by left-to-right square-and-multiply in the Montgomery
// domain, sequencing one mon_prod call at a time.
module mod_exp
    import mod_exp_pkg::*;
#(
    parameter int bitLen = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [bitLen-1:0] X,
    input  logic [bitLen-1:0] E,
    input  logic [bitLen-1:0] M,
    input  logic [bitLen-1:0] R2,
    output logic              busy,
    output logic              stop,
    output logic [bitLen-1:0] Y
);
    localparam int CW = $clog2(bitLen + 1);
    localparam logic [bitLen-1:0] ONE = bitLen'(1);

    state_e            state_q, state_d;
    sub_e              sub_q, sub_d;
    logic [bitLen-1:0] x_q, x_d, e_q, e_d, m_q, m_d, r2_q, r2_d;
    logic [bitLen-1:0] xbar_q, xbar_d, ybar_q, ybar_d, y_q, y_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              first_q, first_d, seen_low_q, seen_low_d;
    logic              op_state, op_done, mp_start, mp_stop;
    logic [bitLen-1:0] mp_A, mp_B, mp_P;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sub_q      <= SUB_LAUNCH;
            x_q        <= '0;
            e_q        <= '0;
            m_q        <= '0;
            r2_q       <= '0;
            xbar_q     <= '0;
            ybar_q     <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            x_q        <= x_d;
            e_q        <= e_d;
            m_q        <= m_d;
            r2_q       <= r2_d;
            xbar_q     <= xbar_d;
            ybar_q     <= ybar_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            seen_low_q <= seen_low_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        x_d        = x_q;
        e_d        = e_q;
        m_d        = m_q;
        r2_d       = r2_q;
        xbar_d     = xbar_q;
        ybar_d     = ybar_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        seen_low_d = seen_low_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    x_d     = X;
                    e_d     = E;
                    m_d     = M;
                    r2_d    = R2;
                    state_d = ST_TO_MONT;
                    sub_d   = SUB_LAUNCH;
                end
            end
            ST_NEXT: begin
                e_d     = e_q << 1;
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? ST_FROM_MONT : ST_SQUARE;
            end
            default: begin
                if (sub_q == SUB_LAUNCH) begin
                    sub_d      = SUB_WAIT;
                    first_d    = 1'b1;
                    seen_low_d = 1'b0;
                end else begin
                    // A stop level left over from an earlier call must fall before it counts.
                    first_d = 1'b0;
                    if (!mp_stop) seen_low_d = 1'b1;
                    if (op_done) begin
                        sub_d = SUB_LAUNCH;
                        case (state_q)
                            ST_TO_MONT: begin
                                xbar_d  = mp_P;
                                state_d = ST_INIT;
                            end
                            ST_INIT: begin
                                ybar_d  = mp_P;
                                cnt_d   = CW'(bitLen);
                                state_d = ST_SQUARE;
                            end
                            ST_SQUARE: begin
                                ybar_d  = mp_P;
                                state_d = e_q[bitLen-1] ? ST_MULT : ST_NEXT;
                            end
                            ST_MULT: begin
                                ybar_d  = mp_P;
                                state_d = ST_NEXT;
                            end
                            default: begin
                                y_d     = mp_P;
                                state_d = ST_DONE;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        mp_A     = '0;
        mp_B     = '0;
        op_state = 1'b1;
        case (state_q)
            ST_TO_MONT:   begin mp_A = x_q;    mp_B = r2_q;   end
            ST_INIT:      begin mp_A = ONE;    mp_B = r2_q;   end
            ST_SQUARE:    begin mp_A = ybar_q; mp_B = ybar_q; end
            ST_MULT:      begin mp_A = ybar_q; mp_B = xbar_q; end
            ST_FROM_MONT: begin mp_A = ybar_q; mp_B = ONE;    end
            default:      op_state = 1'b0;
        endcase
        mp_start = op_state && (sub_q == SUB_LAUNCH);
        op_done  = op_state && (sub_q == SUB_WAIT) && !first_q && mp_stop && seen_low_q;
        busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        stop     = (state_q == ST_DONE);
    end

    assign Y = y_q;

    mon_prod #(
        .bitLen (bitLen),
        .SLICE  (mp_slice_for(bitLen))
    ) u_mon_prod (
        .clk   (clk),
        .reset (reset),
        .start (mp_start),
        .A     (mp_A),
        .B     (mp_B),
        .M     (m_q),
        .P     (mp_P),
        .stop  (mp_stop)
    );

endmodule

// File: tb/tb_mod_exp.sv
// Randomised check of mod_exp against a plain-arithmetic power-mod model.
module tb_mod_exp;
    import mod_exp_pkg::*;

    localparam int BL    = 64;
    localparam int LIMIT = 5000;

    logic          clk = 1'b0;
    logic          reset, start, busy, stop;
    logic [BL-1:0] X, E, M, R2, Y;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    mod_exp #(.bitLen(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .X     (X),
        .E     (E),
        .M     (M),
        .R2    (R2),
        .busy  (busy),
        .stop  (stop),
        .Y     (Y)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, m});
    endfunction

    // Right-to-left binary power, deliberately unlike the hardware order.
    function automatic logic [63:0] powmod(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m);
        logic [63:0] r, b;
        r = 64'd1 % m;
        b = x % m;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = mulmod(r, b, m);
            b = mulmod(b, b, m);
        end
        return r;
    endfunction

    function automatic logic [63:0] r2_of(input logic [63:0] m);
        logic [64:0] r;
        r = 65'd1;
        for (int i = 0; i < 128; i++) begin
            r = r << 1;
            if (r >= {1'b0, m}) r = r - {1'b0, m};
        end
        return r[63:0];
    endfunction

    task automatic run_job(input string tag, input logic [63:0] x, input logic [63:0] e,
                           input logic [63:0] m, input int inject_at,
                           input logic [63:0] inj_x, input int hold);
        logic [63:0] exp_y, got_y;
        int          pulses, cyc;
        bit          busy_ok;
        exp_y = powmod(x, e, m);
        @(negedge clk);
        X = x; E = e; M = m; R2 = r2_of(m); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_stop_drop"}, stop, 1'b0);
        pulses  = 0;
        cyc     = 0;
        busy_ok = 1'b1;
        while (!stop && cyc < LIMIT) begin
            if (dut.mp_start) pulses++;
            if (!busy) busy_ok = 1'b0;
            X  = {$urandom, $urandom};
            E  = {$urandom, $urandom};
            M  = {$urandom, $urandom};
            R2 = {$urandom, $urandom};
            if (cyc == inject_at) begin
                start = 1'b1;
                X     = inj_x;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq({tag, "_done"}, stop, 1'b1);
        check_eq({tag, "_busy_at_stop"}, busy, 1'b0);
        check_eq({tag, "_busy_thru"}, busy_ok, 1'b1);
        check_eq({tag, "_calls"}, 64'(pulses), 64'(3 + BL + $countones(e)));
        got_y = Y;
        if (m[0]) check_eq({tag, "_y"}, got_y, exp_y);
        repeat (hold) begin
            X = {$urandom, $urandom};
            E = {$urandom, $urandom};
            @(negedge clk);
        end
        check_eq({tag, "_stop_hold"}, stop, 1'b1);
        check_eq({tag, "_y_hold"}, Y, got_y);
        $display("job %s: X=%0h E=%0h M=%0h Y=%0h ref=%0h calls=%0d cycles=%0d",
                 tag, x, e, m, got_y, exp_y, pulses, cyc);
    endtask

    initial begin
        logic [63:0] rm, rx, re;
        int          cyc;
        reset = 1'b1; start = 1'b0;
        X = '0; E = '0; M = '0; R2 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_stop", stop, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_y", Y, 64'd0);
        check_eq("rst_mp_start", dut.mp_start, 1'b0);
        reset = 1'b0;

        run_job("t216e5", 64'd216, 64'd5, 64'd311, -1, 64'd0, 3);
        run_job("t2e10", 64'd2, 64'd10, 64'd1019, -1, 64'd0, 2);
        run_job("e1", 64'd123, 64'd1, 64'd311, -1, 64'd0, 2);
        run_job("e0", 64'd216, 64'd0, 64'd311, -1, 64'd0, 2);
        run_job("inject", 64'd216, 64'd5, 64'd311, 50, 64'd7, 0);
        run_job("restart", 64'd2, 64'd10, 64'd1019, -1, 64'd0, 1);
        run_job("m_even", 64'd5, 64'd3, 64'd312, -1, 64'd0, 1);

        @(negedge clk);
        X = 64'd216; E = 64'd5; M = 64'd311; R2 = r2_of(64'd311); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (dut.state_q != ST_SQUARE && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_square", dut.state_q == ST_SQUARE, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_stop", stop, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_y", Y, 64'd0);
        check_eq("midrst_mp_start", dut.mp_start, 1'b0);
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_eq("rst_wins_busy", busy, 1'b0);
        check_eq("rst_wins_mp_start", dut.mp_start, 1'b0);
        run_job("after_rst", 64'd216, 64'd5, 64'd311, -1, 64'd0, 1);

        for (int i = 0; i < 50; i++) begin
            rm = {$urandom, $urandom};
            rm[63] = 1'b0;
            rm[0] = 1'b1;
            if (rm < 64'd3) rm = 64'd3;
            rx = {$urandom, $urandom} % rm;
            re = {$urandom, $urandom};
            run_job($sformatf("rnd%0d", i), rx, re, rm, -1, 64'd0, $urandom_range(1, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
